// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divider,
// counter width helper and parity-sense constants. Imported by the
// transmitter, its baud generator and (later) the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // 50 MHz / 9600 baud
    localparam int DEF_BIT_DIV = 5208;

    // Width able to hold BIT_DIV-1; never below one bit.
    function automatic int cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_BIT_DIV);

    localparam logic PAR_EVEN      = 1'b0;
    localparam logic PAR_ODD_SENSE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Reloadable bit-period down-counter.
// Ports:
//   clk, reset   clock / asynchronous active-low reset
//   clear        force the counter to zero (idle)
//   restart      load BIT_DIV-1 to start a new bit period
//   bit_end      high during the last clock of the current bit period
// The counter parks at zero when neither input is active, so bit_end
// simply reads as high while idle; the FSM ignores it there.
module baud_gen
    import uart_pkg::*;
#(
    parameter int BIT_DIV = DEF_BIT_DIV,
    parameter int CNT_W   = cnt_width(BIT_DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic restart,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// Parallel-to-serial UART transmitter: start bit, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits.
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset (aborts any frame)
//   ld      load strobe, accepted only while tx_rdy is high
//   Din     byte to send, sampled on the accepting edge
//   tx      registered serial output, idles high
//   tx_rdy  idle and able to accept ld
//   done    one-cycle pulse on the cycle after the final stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_DIV   = DEF_BIT_DIV,
    parameter int PAR_EN    = 0,
    parameter int PAR_ODD   = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld,
    input  logic [7:0] Din,
    output logic       tx,
    output logic       tx_rdy,
    output logic       done
);

    localparam logic       PAR_SENSE = (PAR_ODD != 0) ? PAR_ODD_SENSE : PAR_EVEN;
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] idx, idx_n;       // data bit index, reused as stop bit index
    logic       par, par_n;
    logic       tx_n, done_n;
    logic       bit_end, restart, clear;

    baud_gen #(.BIT_DIV(BIT_DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .restart (restart),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shift <= 8'h00;
            idx   <= 3'd0;
            par   <= 1'b0;
            tx    <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            idx   <= idx_n;
            par   <= par_n;
            tx    <= tx_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        par_n   = par;
        done_n  = 1'b0;
        restart = 1'b0;
        clear   = 1'b0;

        case (state)
            IDLE: begin
                if (ld) begin
                    state_n = START;
                    shift_n = Din;
                    par_n   = (^Din) ^ PAR_SENSE;
                    idx_n   = 3'd0;
                    restart = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    restart = 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    restart = 1'b1;
                    shift_n = shift >> 1;
                    if (idx == 3'd7) begin
                        idx_n   = 3'd0;
                        state_n = (PAR_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    restart = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx == LAST_STOP) begin
                        state_n = IDLE;
                        idx_n   = 3'd0;
                        done_n  = 1'b1;
                        clear   = 1'b1;
                    end else begin
                        idx_n   = idx + 3'd1;
                        restart = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is decoded from the next state so the pin changes on the same
        // edge as the state register, with no combinational path to it.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    assign tx_rdy = (state == IDLE);

endmodule
